generador_trans: RTL and testbench
==================================

Name: generador_trans

Overview:
- Transaction stimulus source for the transaction-layer counter path.
- On command, drives a programmed number of distinct data words onto a DATA_W bus.
- Every emitted word differs from the word before it, so a downstream change-detecting counter sees exactly one event per word.
- Keeps its own running count of emitted words, which the bench compares against the downstream counter's count.

Parameters:
- DATA_W, 12: width of the generated data bus.
- CNT_W, 16: width of the transaction count request and of the emitted-word counter.
- GAP_W, 4: width of the inter-word idle-cycle field.
- SEED, 12'h001: non-zero LFSR restart value (used only with GEN_LFSR_EN).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; honoured only in IDLE.
- num_trans  in  CNT_W  number of words to emit; sampled when start is honoured.
- gap  in  GAP_W  idle cycles between consecutive words; sampled when start is honoured.
- data_out  out  DATA_W  generated data word; holds its value between words.
- busy  out  1  high while a burst is in progress (SEND/GAP).
- done  out  1  one-cycle pulse when a burst completes.
- enviados  out  CNT_W  total words emitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low, on port reset.
  - reset==0 at a posedge: state=IDLE, data_out=0, busy=0, done=0, enviados=0, remaining=0, gap counter=0.
  - Reset mid-burst aborts immediately; no partial completion and no done pulse.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 and num_trans!=0: latch remaining=num_trans and gap_l=gap; go to SEND; busy=1 from the next cycle.
  - start=1 and num_trans==0: go to DONE; data_out and enviados unchanged.
  - start=0: stay in IDLE.
- SEND (one cycle per word):
  - data_out<=next(data_out), enviados<=enviados+1, remaining<=remaining-1.
  - If remaining==1: go to DONE.
  - Else if gap_l==0: stay in SEND.
  - Else: go to GAP with gap counter=gap_l.
- GAP: decrement the gap counter; return to SEND when it reaches 1. This gives exactly gap_l idle cycles.
- DONE: done=1 and busy=0 for exactly one cycle; always returns to IDLE.
- start is ignored in SEND, GAP and DONE. num_trans and gap may change freely after being sampled.
- Timing, with start honoured at edge k:
  - Word i (i=0..N-1) is registered at edge k+1+i*(gap_l+1).
  - done is high for the cycle following the last word's edge.
- next() (default): data_out+1 modulo 2^DATA_W.
  - Never equals the previous word.
  - Wrap 4095->0 is legal because the two values differ.
- enviados increments only in SEND; wraps to 0 after 2^CNT_W-1.

Optional Feature:
- Macro: GEN_LFSR_EN.
- Defined: next() is a DATA_W-bit maximal-length Galois LFSR, taps x^12+x^6+x^4+x+1 for DATA_W=12.
  - If data_out==0 (after reset), next()=SEED.
  - Sequence never reaches 0; consecutive words are always distinct (period 4095).
- Not defined: incrementing sequence as above; SEED unused.
- Ports, timing and enviados are identical in both builds.

Decomposition:
- Shared package gen_pkg holds:
  - FSM state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2, DONE=2'd3);
  - default widths DATA_W/CNT_W/GAP_W;
  - LFSR tap mask constant.
- One natural sub-module: gen_next_word.
  - Combinational next-value function, increment or LFSR selected by GEN_LFSR_EN.
  - Zero-to-SEED mapping lives there.
- All sequential logic stays in the top module.

Test Plan:
- Reset held 3 cycles, then released -> data_out=0, enviados=0, busy=0, done=0.
- start with num_trans=5, gap=0 -> data_out 1,2,3,4,5 on 5 consecutive cycles; done one cycle later; enviados=5.
- start with num_trans=3, gap=2 -> words at edges k+1, k+4, k+7; data_out stable in between; done after the third word.
- num_trans=0 -> done pulse the cycle after start; data_out and enviados unchanged; busy never asserted.
- Wrap and count check:
  - Preload via a 4095-word burst, then a 2-word burst -> data_out passes 4095->0->1.
  - The connected change-detecting counter equals enviados (4097).
- Reset asserted mid-burst (word 3 of 10) -> next cycle IDLE, data_out=0, no done.
- start repulsed while busy -> ignored; enviados increases by the original num_trans only.
- GEN_LFSR_EN build, num_trans=4 -> first word=SEED=1, then 3 distinct non-zero LFSR states.

Source files
------------

// File: rtl/gen_pkg.sv
// Shared definitions for the transaction stimulus generator:
// FSM state encoding, default widths and the LFSR feedback mask.
package gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GAP_W  = 4;

    // x^12 + x^6 + x^4 + x + 1 with the x^12 term implied by the shift-out bit.
    localparam logic [11:0] LFSR_TAPS = 12'h053;

endpackage

// File: rtl/gen_next_word.sv
// Combinational next-word function: increment by default, Galois LFSR
// when GEN_LFSR_EN is defined. Ports: cur_i (current word), next_o.
module gen_next_word
    import gen_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
    input  logic [DATA_W-1:0] cur_i,
    output logic [DATA_W-1:0] next_o
);

`ifdef GEN_LFSR_EN
    logic [DATA_W-1:0] taps;
    assign taps = DATA_W'(LFSR_TAPS);

    always_comb begin
        next_o = {cur_i[DATA_W-2:0], 1'b0};
        if (cur_i[DATA_W-1]) begin
            next_o = next_o ^ taps;
        end
        // Zero is the reset value and is not on the LFSR cycle.
        if (cur_i == '0) begin
            next_o = SEED;
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^SEED;
    assign next_o      = cur_i + DATA_W'(1);
`endif

endmodule

// File: rtl/generador_trans.sv
// Transaction stimulus source: emits num_trans distinct words with gap idle
// cycles between them, counts every emitted word in enviados.
// Ports: clk, reset (sync, active-low), start, num_trans, gap,
// data_out, busy, done, enviados. Macro GEN_LFSR_EN selects LFSR words.
module generador_trans
    import gen_pkg::*;
#(
    parameter int                DATA_W = DEF_DATA_W,
    parameter int                CNT_W  = DEF_CNT_W,
    parameter int                GAP_W  = DEF_GAP_W,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_trans,
    input  logic [GAP_W-1:0]  gap,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  enviados
);

    gen_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [GAP_W-1:0]  gapl_q, gapl_d;
    logic [GAP_W-1:0]  gcnt_q, gcnt_d;
    logic [DATA_W-1:0] next_word;

    gen_next_word #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_next (
        .cur_i  (data_q),
        .next_o (next_word)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        gapl_d  = gapl_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_trans != '0) begin
                        rem_d   = num_trans;
                        gapl_d  = gap;
                        state_d = SEND;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SEND: begin
                data_d = next_word;
                cnt_d  = cnt_q + CNT_W'(1);
                rem_d  = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else if (gapl_q != '0) begin
                    gcnt_d  = gapl_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                // Leaving on a count of 1 yields exactly gapl_q idle cycles.
                gcnt_d = gcnt_q - GAP_W'(1);
                if (gcnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            gapl_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            gapl_q  <= gapl_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign data_out = data_q;
    assign enviados = cnt_q;
    assign busy     = (state_q == SEND) || (state_q == GAP);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_generador_trans.sv
// Self-checking bench for generador_trans: directed table, random bursts
// against a timing/sequence model, reset abort and 4097-word wrap.
module tb_generador_trans;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_trans;
    logic [3:0]  gap;
    logic [11:0] data_out;
    logic        busy;
    logic        done;
    logic [15:0] enviados;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_data;
    logic [15:0] m_cnt;

    int          chg;
    logic [11:0] last_seen;

    generador_trans dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_trans (num_trans),
        .gap       (gap),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .enviados  (enviados)
    );

    always #5 clk = ~clk;

    // Downstream change-detecting counter.
    always @(negedge clk) begin
        if (!reset) begin
            chg       = 0;
            last_seen = '0;
        end else if (data_out != last_seen) begin
            chg       = chg + 1;
            last_seen = data_out;
        end
    end

    function automatic logic [11:0] mnext(input logic [11:0] x);
        logic [12:0] p;
`ifdef GEN_LFSR_EN
        // Multiply by t modulo t^12+t^6+t^4+t+1.
        if (x == 12'd0) return 12'h001;
        p = {x, 1'b0};
        if (p[12]) p = p ^ 13'h1053;
        return p[11:0];
`else
        p = {1'b0, x} + 13'd1;
        return p[11:0];
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic eb, input logic ed);
        chk({tag, ".data"}, 32'(data_out), 32'(m_data));
        chk({tag, ".env"}, 32'(enviados), 32'(m_cnt));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        start = 1'b0;
        repeat (cycles) tick();
        m_data = '0;
        m_cnt  = '0;
        reset  = 1'b1;
    endtask

    // Word i lands at edge k+1+i*(g+1); done follows the last word's edge.
    task automatic run_burst(input int n, input int g, input bit poke);
        int          len;
        logic [11:0] prev;
        start     = 1'b1;
        num_trans = 16'(n);
        gap       = 4'(g);
        tick();
        start     = 1'b0;
        num_trans = 16'($urandom);
        gap       = 4'($urandom);
        if (n == 0) begin
            chk_out("zero", 1'b0, 1'b1);
            tick();
            chk_out("zero_idle", 1'b0, 1'b0);
            return;
        end
        len = 1 + (n - 1) * (g + 1);
        chk_out("first", 1'b1, 1'b0);
        for (int t = 1; t <= len; t++) begin
            if (poke) begin
                start     = 1'($urandom);
                num_trans = 16'($urandom_range(1, 50));
            end
            tick();
            if ((t - 1) % (g + 1) == 0) begin
                prev   = m_data;
                m_data = mnext(m_data);
                m_cnt  = m_cnt + 16'd1;
                chk("distinct", 32'(data_out != prev), 32'd1);
            end
            chk_out("burst", t < len, t == len);
        end
        start = 1'b0;
        tick();
        chk_out("after", 1'b0, 1'b0);
    endtask

    typedef struct {
        int          n;
        int          g;
        bit          poke;
        logic [11:0] exp_data;
        logic [15:0] exp_env;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{5, 0, 1'b0, 12'd5,  16'd5};
        tbl[1] = '{3, 2, 1'b0, 12'd8,  16'd8};
        tbl[2] = '{0, 3, 1'b0, 12'd8,  16'd8};
        tbl[3] = '{4, 1, 1'b1, 12'd12, 16'd12};
        tbl[4] = '{1, 0, 1'b1, 12'd13, 16'd13};

        num_trans = '0;
        gap       = '0;
        #1;
        do_reset(3);
        chk_out("reset", 1'b0, 1'b0);
        tick();
        chk_out("post_reset", 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_burst(tbl[i].n, tbl[i].g, tbl[i].poke);
            chk("tbl_env", 32'(enviados), 32'(tbl[i].exp_env));
`ifndef GEN_LFSR_EN
            chk("tbl_data", 32'(data_out), 32'(tbl[i].exp_data));
`endif
        end

        for (int i = 0; i < 30; i++) begin
            run_burst($urandom_range(0, 12), $urandom_range(0, 4), 1'b1);
        end

        // Reset after the third of ten words: abort, no done.
        start     = 1'b1;
        num_trans = 16'd10;
        gap       = 4'd0;
        tick();
        start = 1'b0;
        repeat (3) begin
            tick();
            m_data = mnext(m_data);
            m_cnt  = m_cnt + 16'd1;
        end
        chk_out("pre_abort", 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        m_data = '0;
        m_cnt  = '0;
        chk_out("abort", 1'b0, 1'b0);
        reset = 1'b1;
        repeat (3) begin
            tick();
            chk_out("abort_idle", 1'b0, 1'b0);
        end

        // Wrap: 4095 + 2 words, counter and change detector must agree.
        do_reset(2);
        tick();
        run_burst(4095, 0, 1'b0);
        run_burst(2, 0, 1'b0);
`ifndef GEN_LFSR_EN
        chk("wrap_data", 32'(data_out), 32'd1);
`endif
        chk("wrap_env", 32'(enviados), 32'd4097);
        chk("wrap_chg", 32'(chg), 32'(enviados));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
